fetch_decode_queue: RTL and testbench
=====================================

FETCH_DECODE_QUEUE -- requirements
Module: fetch_decode_queue

Interface
REQ-001 SHALL have parameter FETCH_W, default 4: instruction lanes accepted per cycle.
REQ-002 SHALL have parameter DEC_W, default 4: instruction lanes presented to decode per cycle.
REQ-003 SHALL have parameter DEPTH, default 16: entry count; power of two and at least FETCH_W+DEC_W.
REQ-004 SHALL have port clk, input, 1: the single clock.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL have port flush, input, 1: synchronous pipeline flush.
REQ-007 SHALL have ports in_valid (in, 1) and in_ready (out, 1): fetch handshake; a packet transfers when both are high.
REQ-008 SHALL have port in_mask, in, FETCH_W: per-lane instruction valid.
REQ-009 SHALL have port in_instr, in, FETCH_W*32: lane i occupies bits [32i+31:32i].
REQ-010 SHALL have port in_start_pc, in, 32: PC of lane 0.
REQ-011 SHALL have ports in_pred_taken (in, 1) and in_pred_cut_pos (in, clog2(FETCH_W)): predicted-taken flag and the lane that holds it.
REQ-012 SHALL have ports out_valid (out, DEC_W), out_instr (out, DEC_W*32) and out_pc (out, DEC_W*32): oldest-first lanes.
REQ-013 SHALL have port out_pred_taken, out, DEC_W: per-lane predicted-taken mark.
REQ-014 SHALL have port out_ready, in, 1: decode accepts every presented lane (all-or-nothing).
REQ-015 SHALL have port count, out, clog2(DEPTH)+1: current occupancy.

Function
REQ-016 SHALL set enq_n to popcount(in_mask) when in_valid&&in_ready, and to 0 otherwise.
REQ-017 SHALL write the enabled lanes contiguously at the tail, in ascending lane order, with no holes.
REQ-018 SHALL store each entry's pc as in_start_pc+4*lane, computed modulo 2^32.
REQ-019 SHALL store an entry's pred mark as 1 only when in_pred_taken=1 and the lane equals in_pred_cut_pos; an unmasked cut lane marks no entry.
REQ-020 SHALL drive in_ready = (DEPTH-count >= FETCH_W), taken from the registered count only, with no path from out_ready.
REQ-021 SHALL drive out_valid lower min(count,DEC_W) bits high and all other bits 0; data lanes are read combinationally from the head.
REQ-022 SHALL set deq_n = popcount(out_valid) when out_ready=1, and 0 otherwise.
REQ-023 SHALL update count <= count+enq_n-deq_n, so simultaneous enqueue and dequeue both apply in the same cycle.
REQ-024 SHALL advance head and tail pointers by deq_n and enq_n modulo DEPTH, wrapping naturally; an entry may straddle index DEPTH-1 to 0.
REQ-025 SHALL treat in_valid=1 with in_mask=0 as a no-op.
REQ-026 SHALL make flush highest priority: next cycle count=0, head=tail=0, and any same-cycle enqueue or dequeue is discarded.
REQ-027 SHALL give an enqueued entry a latency of 1 cycle from accept to out_valid, unless the configuration option below changes it.
REQ-028 SHALL never overflow (guaranteed by REQ-020) and never underflow (guaranteed by REQ-021).

Reset
REQ-029 SHALL, on rst_n low, asynchronously clear count, head, tail and all pred marks; instruction and pc storage need not be reset.
REQ-030 SHALL, during and after reset, give out_valid=0, in_ready=1 and count=0; reset mid-transfer discards every entry.

Configuration
REQ-031 SHALL implement the same-cycle bypass when macro FETCH_DECODE_QUEUE_BYPASS_EN is defined: if count=0 and in_valid&&in_ready, the compacted input lanes drive out_* combinationally with out_valid=min(enq_n,DEC_W).
REQ-032 SHALL, with bypass active and out_ready=1, write only the enq_n-deq_n lanes not dequeued; with out_ready=0, write all enq_n lanes.
REQ-033 SHALL, with the macro undefined, present out_* from storage only (latency 1) and contain no combinational path from in_* to out_*.

Verification
REQ-034 SHALL cover compaction: in_mask=4'b1010, in_start_pc=0x1C000000 -> next cycle out_valid=4'b0011, out_pc={0x1C000004,0x1C00000C}, count=2.
REQ-035 SHALL cover fill and stall: five 4-lane packets with out_ready=0 -> in_ready drops after count=16, and the fifth packet stays held.
REQ-036 SHALL cover wrap-around: with head=14 and 4 lanes enqueued, then 4 dequeued -> data ordered indices 14,15,0,1 and pcs consecutive.
REQ-037 SHALL cover simultaneous events: count=6, enqueue 3, dequeue 4 in one cycle -> count=5.
REQ-038 SHALL cover flush: flush asserted with in_valid=1 and count=9 -> next cycle count=0, out_valid=0, nothing written.
REQ-039 SHALL cover the prediction mark and bypass: in_pred_taken=1, cut_pos=2, mask 4'b0111, empty queue, macro defined, out_ready=1 -> same cycle out_valid=4'b0111, out_pred_taken=4'b0100, count stays 0.

Source files
------------

// File: rtl/fetch_decode_queue.sv
// Compacting fetch-to-decode instruction queue with oldest-first multi-lane output.
// Define FETCH_DECODE_QUEUE_BYPASS_EN to present an empty queue's incoming packet in the same cycle.
module fetch_decode_queue #(
  parameter int FETCH_W = 4,
  parameter int DEC_W   = 4,
  parameter int DEPTH   = 16
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          flush,
  input  logic                                          in_valid,
  output logic                                          in_ready,
  input  logic [FETCH_W-1:0]                            in_mask,
  input  logic [FETCH_W*32-1:0]                         in_instr,
  input  logic [31:0]                                   in_start_pc,
  input  logic                                          in_pred_taken,
  input  logic [((FETCH_W > 1) ? $clog2(FETCH_W) : 1)-1:0] in_pred_cut_pos,
  output logic [DEC_W-1:0]                              out_valid,
  output logic [DEC_W*32-1:0]                           out_instr,
  output logic [DEC_W*32-1:0]                           out_pc,
  output logic [DEC_W-1:0]                              out_pred_taken,
  input  logic                                          out_ready,
  output logic [$clog2(DEPTH):0]                        count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int CUT_W = (FETCH_W > 1) ? $clog2(FETCH_W) : 1;
  localparam logic [CNT_W-1:0] DEC_N    = CNT_W'(DEC_W);
  localparam logic [CNT_W-1:0] IN_LIMIT = CNT_W'(DEPTH - FETCH_W);

  logic [31:0]      instr_q [DEPTH];
  logic [31:0]      pc_q    [DEPTH];
  logic [DEPTH-1:0] pred_q;
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             accept;
  logic             byp_active;
  logic [CNT_W-1:0] mask_pop, enq_n, deq_n, pres_n;
  logic [PTR_W-1:0] lane_off [FETCH_W];
  logic [PTR_W-1:0] wr_idx   [FETCH_W];
  logic [31:0]      lane_pc  [FETCH_W];
  logic [FETCH_W-1:0] lane_pred, lane_wr;
  logic [PTR_W-1:0] rd_idx   [DEC_W];

  // in_ready looks only at registered occupancy so decode backpressure never reaches fetch.
  assign in_ready = (count_q <= IN_LIMIT);
  assign accept   = in_valid && in_ready;
  assign count    = count_q;

  always_comb begin
    mask_pop = '0;
    for (int i = 0; i < FETCH_W; i++) begin
      lane_off[i]  = mask_pop[PTR_W-1:0];
      wr_idx[i]    = tail_q + mask_pop[PTR_W-1:0];
      lane_pred[i] = in_pred_taken && (in_pred_cut_pos == CUT_W'(i));
      lane_pc[i]   = in_start_pc + 32'(4 * i);
      mask_pop     = mask_pop + CNT_W'(in_mask[i]);
    end
  end

  assign enq_n = accept ? mask_pop : '0;

`ifdef FETCH_DECODE_QUEUE_BYPASS_EN
  logic [31:0]      byp_instr [DEC_W];
  logic [31:0]      byp_pc    [DEC_W];
  logic [DEC_W-1:0] byp_pred;

  assign byp_active = rst_n && accept && (count_q == '0);

  always_comb begin
    for (int j = 0; j < DEC_W; j++) begin
      byp_instr[j] = '0;
      byp_pc[j]    = '0;
      byp_pred[j]  = 1'b0;
      for (int i = 0; i < FETCH_W; i++) begin
        if (in_mask[i] && (CNT_W'(lane_off[i]) == CNT_W'(j))) begin
          byp_instr[j] = in_instr[32*i +: 32];
          byp_pc[j]    = lane_pc[i];
          byp_pred[j]  = lane_pred[i];
        end
      end
    end
  end
`else
  assign byp_active = 1'b0;
`endif

  always_comb begin
    if (byp_active) pres_n = (enq_n < DEC_N) ? enq_n : DEC_N;
    else            pres_n = (count_q < DEC_N) ? count_q : DEC_N;
    deq_n = out_ready ? pres_n : '0;
  end

  always_comb begin
    for (int j = 0; j < DEC_W; j++) begin
      rd_idx[j]             = head_q + PTR_W'(j);
      out_valid[j]          = (CNT_W'(j) < pres_n);
      out_instr[32*j +: 32] = instr_q[rd_idx[j]];
      out_pc[32*j +: 32]    = pc_q[rd_idx[j]];
      out_pred_taken[j]     = pred_q[rd_idx[j]] && out_valid[j];
`ifdef FETCH_DECODE_QUEUE_BYPASS_EN
      if (byp_active) begin
        out_instr[32*j +: 32] = byp_instr[j];
        out_pc[32*j +: 32]    = byp_pc[j];
        out_pred_taken[j]     = byp_pred[j] && out_valid[j];
      end
`endif
    end
  end

  // Lanes consumed by the bypass in this same cycle are never stored.
  always_comb begin
    for (int i = 0; i < FETCH_W; i++) begin
      lane_wr[i] = accept && !flush && in_mask[i] &&
                   (!byp_active || (CNT_W'(lane_off[i]) >= deq_n));
    end
  end

  always_comb begin
    head_d  = head_q + deq_n[PTR_W-1:0];
    tail_d  = tail_q + enq_n[PTR_W-1:0];
    count_d = count_q + enq_n - deq_n;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      pred_q  <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      for (int i = 0; i < FETCH_W; i++) begin
        if (lane_wr[i]) pred_q[wr_idx[i]] <= lane_pred[i];
      end
    end
  end

  // Payload storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < FETCH_W; i++) begin
      if (lane_wr[i]) begin
        instr_q[wr_idx[i]] <= in_instr[32*i +: 32];
        pc_q[wr_idx[i]]    <= lane_pc[i];
      end
    end
  end

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Directed self-checking bench for fetch_decode_queue at default parameters.
// Bypass expectations follow FETCH_DECODE_QUEUE_BYPASS_EN when it is defined for the build.
module tb_fetch_decode_queue;

  logic         clk;
  logic         rst_n;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   in_mask;
  logic [127:0] in_instr;
  logic [31:0]  in_start_pc;
  logic         in_pred_taken;
  logic [1:0]   in_pred_cut_pos;
  logic [3:0]   out_valid;
  logic [127:0] out_instr;
  logic [127:0] out_pc;
  logic [3:0]   out_pred_taken;
  logic         out_ready;
  logic [4:0]   count;

  int checks = 0;
  int errors = 0;

  fetch_decode_queue #(.FETCH_W(4), .DEC_W(4), .DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_mask(in_mask),
    .in_instr(in_instr), .in_start_pc(in_start_pc),
    .in_pred_taken(in_pred_taken), .in_pred_cut_pos(in_pred_cut_pos),
    .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
    .out_pred_taken(out_pred_taken), .out_ready(out_ready), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_packet(input logic [3:0] m, input logic [31:0] ibase, input logic [31:0] pc);
    in_valid      = 1'b1;
    in_mask       = m;
    in_start_pc   = pc;
    in_pred_taken = 1'b0;
    for (int l = 0; l < 4; l++) in_instr[32*l +: 32] = ibase + 32'(l);
  endtask

  // One clock edge, then inputs return to idle and outputs settle.
  task automatic tick();
    @(posedge clk);
    #1;
    in_valid      = 1'b0;
    out_ready     = 1'b0;
    flush         = 1'b0;
    in_pred_taken = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_packet(4'b1111, 32'h1111_0000, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
    checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL reset_out_valid got %b want 0000", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL post_reset_count got %0d want 0", count); end
  endtask

  task automatic test_compaction();
    set_packet(4'b1010, 32'hA000_0000, 32'h1C00_0000);
    tick();
    checks++; if (count !== 5'd2) begin errors++; $display("FAIL comp_count got %0d want 2", count); end
    checks++; if (out_valid !== 4'b0011) begin errors++; $display("FAIL comp_out_valid got %b want 0011", out_valid); end
    checks++; if (out_pc[31:0] !== 32'h1C00_0004) begin errors++; $display("FAIL comp_pc0 got %h want 1c000004", out_pc[31:0]); end
    checks++; if (out_pc[63:32] !== 32'h1C00_000C) begin errors++; $display("FAIL comp_pc1 got %h want 1c00000c", out_pc[63:32]); end
    checks++; if (out_instr[31:0] !== 32'hA000_0001) begin errors++; $display("FAIL comp_instr0 got %h want a0000001", out_instr[31:0]); end
    checks++; if (out_instr[63:32] !== 32'hA000_0003) begin errors++; $display("FAIL comp_instr1 got %h want a0000003", out_instr[63:32]); end
    out_ready = 1'b1;
    tick();
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL comp_drain_count got %0d want 0", count); end
  endtask

  task automatic test_fill_stall();
    for (int p = 0; p < 4; p++) begin
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fill_ready_%0d got %b want 1", p, in_ready); end
      set_packet(4'b1111, 32'hB000_0000 + 32'(16*p), 32'h1000 + 32'(16*p));
      tick();
    end
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL fill_count got %0d want 16", count); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_full_ready got %b want 0", in_ready); end
    set_packet(4'b1111, 32'hB000_0040, 32'h1040);
    @(posedge clk);
    #1;
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL fill_held_count got %0d want 16", count); end
    out_ready = 1'b1;
    tick();
    checks++; if (count !== 5'd12) begin errors++; $display("FAIL fill_deq_count got %0d want 12", count); end
    checks++; if (out_instr[31:0] !== 32'hB000_0010) begin errors++; $display("FAIL fill_head got %h want b0000010", out_instr[31:0]); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fill_reopen_ready got %b want 1", in_ready); end
    set_packet(4'b1111, 32'hB000_0040, 32'h1040);
    tick();
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL fill_fifth_count got %0d want 16", count); end
    for (int k = 0; k < 3; k++) begin
      out_ready = 1'b1;
      tick();
    end
    checks++; if (out_instr[127:96] !== 32'hB000_0043) begin errors++; $display("FAIL fill_fifth_instr3 got %h want b0000043", out_instr[127:96]); end
    checks++; if (out_pc[127:96] !== 32'h0000_104C) begin errors++; $display("FAIL fill_fifth_pc3 got %h want 0000104c", out_pc[127:96]); end
    flush = 1'b1;
    tick();
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL fill_flush_count got %0d want 0", count); end
  endtask

  task automatic test_wrap();
    for (int k = 0; k < 7; k++) begin
      set_packet(4'b0011, 32'hC000_0000, 32'h0);
      tick();
      out_ready = 1'b1;
      tick();
    end
    set_packet(4'b1111, 32'hD000_0000, 32'h2000);
    tick();
    checks++; if (count !== 5'd4) begin errors++; $display("FAIL wrap_count got %0d want 4", count); end
    for (int l = 0; l < 4; l++) begin
      checks++; if (out_instr[32*l +: 32] !== 32'hD000_0000 + 32'(l)) begin errors++; $display("FAIL wrap_instr%0d got %h want %h", l, out_instr[32*l +: 32], 32'hD000_0000 + 32'(l)); end
      checks++; if (out_pc[32*l +: 32] !== 32'h2000 + 32'(4*l)) begin errors++; $display("FAIL wrap_pc%0d got %h want %h", l, out_pc[32*l +: 32], 32'h2000 + 32'(4*l)); end
    end
    out_ready = 1'b1;
    tick();
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL wrap_drain_count got %0d want 0", count); end
  endtask

  task automatic test_simultaneous();
    set_packet(4'b1111, 32'hE000_0000, 32'h4000);
    tick();
    set_packet(4'b0011, 32'hE000_0010, 32'h4010);
    tick();
    checks++; if (count !== 5'd6) begin errors++; $display("FAIL sim_pre_count got %0d want 6", count); end
    set_packet(4'b0111, 32'hE000_0020, 32'h4020);
    out_ready = 1'b1;
    tick();
    checks++; if (count !== 5'd5) begin errors++; $display("FAIL sim_count got %0d want 5", count); end
    checks++; if (out_instr[31:0] !== 32'hE000_0010) begin errors++; $display("FAIL sim_lane0 got %h want e0000010", out_instr[31:0]); end
    checks++; if (out_instr[95:64] !== 32'hE000_0020) begin errors++; $display("FAIL sim_lane2 got %h want e0000020", out_instr[95:64]); end
    checks++; if (out_pc[95:64] !== 32'h0000_4020) begin errors++; $display("FAIL sim_pc2 got %h want 00004020", out_pc[95:64]); end
  endtask

  task automatic test_flush();
    flush = 1'b1;
    tick();
    set_packet(4'b1111, 32'hF000_0000, 32'h5000);
    tick();
    set_packet(4'b1111, 32'hF000_0010, 32'h5010);
    tick();
    set_packet(4'b0001, 32'hF000_0020, 32'h5020);
    tick();
    checks++; if (count !== 5'd9) begin errors++; $display("FAIL flush_pre_count got %0d want 9", count); end
    set_packet(4'b1111, 32'hF000_0030, 32'h5030);
    flush = 1'b1;
    out_ready = 1'b1;
    tick();
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL flush_count got %0d want 0", count); end
    checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL flush_out_valid got %b want 0000", out_valid); end
    set_packet(4'b0001, 32'hF000_0040, 32'h6000);
    tick();
    checks++; if (count !== 5'd1) begin errors++; $display("FAIL flush_after_count got %0d want 1", count); end
    checks++; if (out_instr[31:0] !== 32'hF000_0040) begin errors++; $display("FAIL flush_after_instr got %h want f0000040", out_instr[31:0]); end
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_pred_bypass();
    set_packet(4'b0111, 32'h9000_0000, 32'h3000);
    in_pred_taken   = 1'b1;
    in_pred_cut_pos = 2'd2;
    out_ready       = 1'b1;
    #1;
`ifdef FETCH_DECODE_QUEUE_BYPASS_EN
    checks++; if (out_valid !== 4'b0111) begin errors++; $display("FAIL byp_out_valid got %b want 0111", out_valid); end
    checks++; if (out_pred_taken !== 4'b0100) begin errors++; $display("FAIL byp_pred got %b want 0100", out_pred_taken); end
    checks++; if (out_pc[95:64] !== 32'h0000_3008) begin errors++; $display("FAIL byp_pc2 got %h want 00003008", out_pc[95:64]); end
    tick();
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL byp_count got %0d want 0", count); end
`else
    checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL nobyp_same_cycle got %b want 0000", out_valid); end
    tick();
    checks++; if (count !== 5'd3) begin errors++; $display("FAIL pred_count got %0d want 3", count); end
    checks++; if (out_valid !== 4'b0111) begin errors++; $display("FAIL pred_out_valid got %b want 0111", out_valid); end
    checks++; if (out_pred_taken !== 4'b0100) begin errors++; $display("FAIL pred_mark got %b want 0100", out_pred_taken); end
    checks++; if (out_pc[95:64] !== 32'h0000_3008) begin errors++; $display("FAIL pred_pc2 got %h want 00003008", out_pc[95:64]); end
    out_ready = 1'b1;
    tick();
`endif
    set_packet(4'b0011, 32'h9100_0000, 32'h3100);
    in_pred_taken   = 1'b1;
    in_pred_cut_pos = 2'd2;
    tick();
    checks++; if (count !== 5'd2) begin errors++; $display("FAIL pred_unmasked_count got %0d want 2", count); end
    checks++; if (out_pred_taken !== 4'b0000) begin errors++; $display("FAIL pred_unmasked_mark got %b want 0000", out_pred_taken); end
    flush = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid();
    set_packet(4'b1111, 32'h8000_0000, 32'h7000);
    tick();
    checks++; if (count !== 5'd4) begin errors++; $display("FAIL rmid_pre_count got %0d want 4", count); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL rmid_count got %0d want 0", count); end
    checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL rmid_out_valid got %b want 0000", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rmid_in_ready got %b want 1", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL rmid_after_count got %0d want 0", count); end
  endtask

  initial begin
    flush           = 1'b0;
    in_valid        = 1'b0;
    in_mask         = '0;
    in_instr        = '0;
    in_start_pc     = '0;
    in_pred_taken   = 1'b0;
    in_pred_cut_pos = '0;
    out_ready       = 1'b0;
    test_reset();
    test_compaction();
    test_fill_stall();
    test_wrap();
    test_simultaneous();
    test_flush();
    test_pred_bypass();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
